// File: rtl/sync_conditioner.sv
// sync_conditioner
//   Input stage ahead of the csync generator. Synchronises the raw Atari hsync/vsync
//   pins into the clk domain, rejects glitches shorter than FILTER_TICKS synced
//   samples, and emits clean levels plus one-cycle strobes (hsync falling, vsync
//   rising). Optionally measures the line period, tracks lock and counts lines.
//
//   Build option: SYNC_COND_MEASURE_EN
//     defined   - period counter, line_period and lock tracking are built
//     undefined - line_period is tied to 0 and locked is tied to 1
//
//   Ports
//     clk          in   1   PLL clock, all logic on posedge
//     rst          in   1   asynchronous reset, active-high
//     hsync_in     in   1   raw hsync pin (async, active-low pulse)
//     vsync_in     in   1   raw vsync pin (async)
//     hsync        out  1   filtered hsync level
//     vsync        out  1   filtered vsync level
//     hpulse       out  1   one-cycle strobe, filtered hsync falling edge
//     vpulse       out  1   one-cycle strobe, filtered vsync rising edge
//     line_period  out  16  clk cycles between the last two hpulses
//     line_cnt     out  9   hpulses since the last vpulse, saturating at 511
//     locked       out  1   line period stable within tolerance
module sync_conditioner #(
   parameter int unsigned FILTER_TICKS = 4,
   parameter int unsigned NOM_TICKS    = 6510,
   parameter int unsigned TOL_TICKS    = 16,
   parameter int unsigned LOCK_LINES   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic        hsync,
   output logic        vsync,
   output logic        hpulse,
   output logic        vpulse,
   output logic [15:0] line_period,
   output logic [8:0]  line_cnt,
   output logic        locked
);

   localparam int unsigned FW = $clog2(FILTER_TICKS + 1);

   logic          hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
   logic          hs_q, hs_d, vs_q, vs_d;
   logic [FW-1:0] hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
   logic          hpulse_q, hpulse_d, vpulse_q, vpulse_d;
   logic [8:0]    line_cnt_q, line_cnt_d;

   always_comb begin
      hs_d       = hs_q;
      vs_d       = vs_q;
      hs_cnt_d   = '0;
      vs_cnt_d   = '0;
      line_cnt_d = line_cnt_q;

      // Only an unbroken run of disagreeing samples flips the level.
      if (hs_s2_q != hs_q) begin
         if (hs_cnt_q + FW'(1) == FW'(FILTER_TICKS)) begin
            hs_d = hs_s2_q;
         end else begin
            hs_cnt_d = hs_cnt_q + FW'(1);
         end
      end
      if (vs_s2_q != vs_q) begin
         if (vs_cnt_q + FW'(1) == FW'(FILTER_TICKS)) begin
            vs_d = vs_s2_q;
         end else begin
            vs_cnt_d = vs_cnt_q + FW'(1);
         end
      end

      // Strobes are registered alongside the level so they coincide with the
      // first cycle in which the new level is visible.
      hpulse_d = hs_q & ~hs_d;
      vpulse_d = ~vs_q & vs_d;

      // vpulse has priority over a coincident hpulse.
      if (vpulse_q) begin
         line_cnt_d = '0;
      end else if (hpulse_q && line_cnt_q != '1) begin
         line_cnt_d = line_cnt_q + 9'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_s1_q    <= 1'b1;
         hs_s2_q    <= 1'b1;
         vs_s1_q    <= 1'b1;
         vs_s2_q    <= 1'b1;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         hs_cnt_q   <= '0;
         vs_cnt_q   <= '0;
         hpulse_q   <= 1'b0;
         vpulse_q   <= 1'b0;
         line_cnt_q <= '0;
      end else begin
         hs_s1_q    <= hsync_in;
         hs_s2_q    <= hs_s1_q;
         vs_s1_q    <= vsync_in;
         vs_s2_q    <= vs_s1_q;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         hs_cnt_q   <= hs_cnt_d;
         vs_cnt_q   <= vs_cnt_d;
         hpulse_q   <= hpulse_d;
         vpulse_q   <= vpulse_d;
         line_cnt_q <= line_cnt_d;
      end
   end

   assign hsync    = hs_q;
   assign vsync    = vs_q;
   assign hpulse   = hpulse_q;
   assign vpulse   = vpulse_q;
   assign line_cnt = line_cnt_q;

`ifdef SYNC_COND_MEASURE_EN
   localparam int unsigned GW = $clog2(LOCK_LINES + 1);
   localparam logic [16:0] NOM17 = 17'(NOM_TICKS);
   localparam logic [16:0] TOL17 = 17'(TOL_TICKS);

   logic [15:0]   per_cnt_q, per_cnt_d;
   logic [15:0]   line_period_q, line_period_d;
   logic [GW-1:0] good_q, good_d;
   logic          valid_q, valid_d;
   logic          locked_q, locked_d;
   logic [16:0]   period;
   logic          in_tol;

   always_comb begin
      per_cnt_d     = per_cnt_q;
      line_period_d = line_period_q;
      good_d        = good_q;
      valid_d       = valid_q;
      locked_d      = locked_q;

      // The counter reads period-1 in the hpulse cycle.
      period = {1'b0, per_cnt_q} + 17'd1;
      if (period >= NOM17) begin
         in_tol = (period - NOM17) <= TOL17;
      end else begin
         in_tol = (NOM17 - period) <= TOL17;
      end

      if (hpulse_q) begin
         per_cnt_d = '0;
         valid_d   = 1'b1;
         if (per_cnt_q == '1) begin
            // Saturated in this very cycle: treat as lost sync, no measurement.
            good_d   = '0;
            locked_d = 1'b0;
         end else if (valid_q) begin
            line_period_d = period[15:0];
            if (in_tol) begin
               if (good_q >= GW'(LOCK_LINES - 1)) begin
                  good_d   = GW'(LOCK_LINES);
                  locked_d = 1'b1;
               end else begin
                  good_d = good_q + GW'(1);
               end
            end else begin
               good_d   = '0;
               locked_d = 1'b0;
            end
         end
      end else if (per_cnt_q == '1) begin
         // hsync lost: hold the count and forget the measurement history.
         valid_d  = 1'b0;
         good_d   = '0;
         locked_d = 1'b0;
      end else begin
         per_cnt_d = per_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_cnt_q     <= '0;
         line_period_q <= '0;
         good_q        <= '0;
         valid_q       <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         per_cnt_q     <= per_cnt_d;
         line_period_q <= line_period_d;
         good_q        <= good_d;
         valid_q       <= valid_d;
         locked_q      <= locked_d;
      end
   end

   assign line_period = line_period_q;
   assign locked      = locked_q;
`else
   assign line_period = '0;
   assign locked      = 1'b1;
`endif

endmodule

// File: tb/tb_sync_conditioner.sv
// Directed bench for sync_conditioner with a small expected-result scoreboard:
// every hsync falling edge driven pushes the line_period / locked / line_cnt
// expected one cycle after the resulting hpulse.
module tb_sync_conditioner;

   localparam int NOM = 100;
   localparam int TOL = 4;
`ifdef SYNC_COND_MEASURE_EN
   localparam bit MEAS = 1'b1;
`else
   localparam bit MEAS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hsync_in;
   logic        vsync_in;
   logic        hsync;
   logic        vsync;
   logic        hpulse;
   logic        vpulse;
   logic [15:0] line_period;
   logic [8:0]  line_cnt;
   logic        locked;

   sync_conditioner #(
      .FILTER_TICKS (4),
      .NOM_TICKS    (NOM),
      .TOL_TICKS    (TOL),
      .LOCK_LINES   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hsync       (hsync),
      .vsync       (vsync),
      .hpulse      (hpulse),
      .vpulse      (vpulse),
      .line_period (line_period),
      .line_cnt    (line_cnt),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [15:0] lp;
      logic        lk;
      logic [8:0]  lc;
   } exp_t;
   exp_t sb[$];

   // Reference model of the measurement, advanced at each driven hsync fall.
   bit          m_valid;
   int          m_good;
   bit          m_locked;
   logic [15:0] m_lp;
   int          m_lc;
   int unsigned m_last;

   task automatic model_reset();
      m_valid  = 1'b0;
      m_good   = 0;
      m_locked = 1'b0;
      m_lp     = '0;
      m_lc     = 0;
   endtask

   task automatic expect_hpulse(input bit with_vpulse);
      int unsigned p;
      int          d;
      exp_t        e;
      p = cyc - m_last;
      if (p >= 65536) begin
         m_good   = 0;
         m_locked = 1'b0;
      end else if (m_valid) begin
         m_lp = p[15:0];
         d = int'(p) - NOM;
         if (d <= TOL && d >= -TOL) begin
            m_good = (m_good < 8) ? m_good + 1 : 8;
            if (m_good == 8) m_locked = 1'b1;
         end else begin
            m_good   = 0;
            m_locked = 1'b0;
         end
      end
      m_valid = 1'b1;
      m_last  = cyc;
      m_lc    = with_vpulse ? 0 : ((m_lc < 511) ? m_lc + 1 : 511);
      e.lp = MEAS ? m_lp : 16'd0;
      e.lk = MEAS ? m_locked : 1'b1;
      e.lc = 9'(m_lc);
      sb.push_back(e);
   endtask

   task automatic line(input int lo, input int hi, input bit vs);
      expect_hpulse(vs);
      hsync_in = 1'b0;
      if (vs) vsync_in = 1'b1;
      repeat (lo) @(negedge clk);
      hsync_in = 1'b1;
      repeat (hi) @(negedge clk);
   endtask

   task automatic vsync_clear();
      vsync_in = 1'b0;
      repeat (8) @(negedge clk);
      vsync_in = 1'b1;
      repeat (5) @(negedge clk);
      check("vpulse_early", vpulse, 1'b0);
      @(negedge clk);
      check("vpulse_edge", vpulse, 1'b1);
      check("vsync_rise", vsync, 1'b1);
      @(negedge clk);
      check("vpulse_single", vpulse, 1'b0);
      check("line_cnt_after_vpulse", line_cnt, 9'd0);
      m_lc = 0;
   endtask

   // Scoreboard consumer: one cycle after each hpulse the outputs must match.
   logic hp_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hp_prev <= 1'b0;
      end else begin
         if (hp_prev) begin
            check("hpulse_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("line_period", line_period, e.lp);
               check("locked", locked, e.lk);
               check("line_cnt", line_cnt, e.lc);
            end
         end
         hp_prev <= hpulse;
      end
   end

   initial begin
      rst      = 1'b1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      model_reset();
      m_last = 0;
      repeat (3) @(negedge clk);
      check("rst_hsync", hsync, 1'b1);
      check("rst_vsync", vsync, 1'b1);
      check("rst_hpulse", hpulse, 1'b0);
      check("rst_vpulse", vpulse, 1'b0);
      check("rst_line_period", line_period, 16'd0);
      check("rst_line_cnt", line_cnt, 9'd0);
      check("rst_locked", locked, MEAS ? 1'b0 : 1'b1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Glitch of 3 cycles must not reach the output.
      hsync_in = 1'b0;
      repeat (3) @(negedge clk);
      hsync_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("glitch_hsync", hsync, 1'b1);
         check("glitch_hpulse", hpulse, 1'b0);
      end

      // Held low: hsync falls 6 cycles after the raw edge with one hpulse.
      expect_hpulse(1'b0);
      hsync_in = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         check("fall_hsync", hsync, (i < 6) ? 1'b1 : 1'b0);
         check("fall_hpulse", hpulse, (i == 6) ? 1'b1 : 1'b0);
      end
      repeat (3) @(negedge clk);
      hsync_in = 1'b1;
      repeat (NOM - 10) @(negedge clk);

      // Nominal stream: lock builds up over the following lines.
      for (int i = 0; i < 9; i++) line(10, NOM - 10, 1'b0);
      // One out-of-tolerance line, then re-lock, then both tolerance edges.
      line(10, NOM + TOL + 1 - 10, 1'b0);
      for (int i = 0; i < 9; i++) line(10, NOM - 10, 1'b0);
      line(10, NOM - TOL - 10, 1'b0);
      line(10, NOM + TOL - 10, 1'b0);

      // Asynchronous reset mid-line with hsync low and counters busy.
      expect_hpulse(1'b0);
      hsync_in = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_hsync", hsync, 1'b0);
      check("pre_rst_locked", locked, MEAS ? m_locked : 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_hsync", hsync, 1'b1);
      check("async_rst_vsync", vsync, 1'b1);
      check("async_rst_hpulse", hpulse, 1'b0);
      check("async_rst_vpulse", vpulse, 1'b0);
      check("async_rst_line_period", line_period, 16'd0);
      check("async_rst_line_cnt", line_cnt, 9'd0);
      check("async_rst_locked", locked, MEAS ? 1'b0 : 1'b1);
      hsync_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("sb_empty_at_rst", sb.size(), 0);
      repeat (4) @(negedge clk);

      // Line counting, vsync clearing, saturation and coincident strobes.
      vsync_clear();
      for (int i = 0; i < 312; i++) line(5, 7, 1'b0);
      check("line_cnt_312", line_cnt, 9'd312);
      vsync_clear();
      for (int i = 0; i < 515; i++) line(5, 7, 1'b0);
      check("line_cnt_sat", line_cnt, 9'd511);
      vsync_in = 1'b0;
      repeat (8) @(negedge clk);
      line(5, 7, 1'b1);
      check("line_cnt_coincident", line_cnt, 9'd0);

      // Re-lock, then lose hsync long enough to saturate the period counter.
      for (int i = 0; i < 10; i++) line(10, NOM - 10, 1'b0);
      check("locked_before_stall", locked, 1'b1);
      repeat (66000) @(negedge clk);
      check("stall_locked", locked, MEAS ? 1'b0 : 1'b1);
      check("stall_line_period", line_period, MEAS ? 16'(NOM) : 16'd0);
      line(10, NOM - 10, 1'b0);
      line(10, NOM - 10, 1'b0);
      line(10, NOM - 10, 1'b0);
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
